// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO core and its storage.
package fifo_pkg;

    localparam int unsigned FIFO_DLEN_DEF = 8;
    localparam int unsigned FIFO_ALEN_DEF = 8;

endpackage

// File: rtl/sync_fifo_core_if.sv
// Producer/consumer port bundle of the FIFO core; the FIFO sits on the slave side.
interface sync_fifo_core_if
    import fifo_pkg::*;
#(
    parameter int unsigned DLEN = FIFO_DLEN_DEF
);

    logic            i_wen;
    logic [DLEN-1:0] i_wdata;
    logic            o_wfull;
    logic            i_ren;
    logic [DLEN-1:0] o_rdata;
    logic            o_rempty;

    modport master (
        output i_wen, i_wdata, i_ren,
        input  o_wfull, o_rdata, o_rempty
    );

    modport slave (
        input  i_wen, i_wdata, i_ren,
        output o_wfull, o_rdata, o_rempty
    );

endinterface

// File: rtl/sdp_ram1.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sdp_ram1
    import fifo_pkg::*;
#(
    parameter int unsigned DLEN = FIFO_DLEN_DEF,
    parameter int unsigned ALEN = FIFO_ALEN_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wen,
    input  logic [ALEN-1:0] i_waddr,
    input  logic [DLEN-1:0] i_wdata,
    input  logic            i_ren,
    input  logic [ALEN-1:0] i_raddr,
    output logic [DLEN-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ALEN;

    logic [DLEN-1:0] mem [0:DEPTH-1];
    logic [DLEN-1:0] rdata_q;

    // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (i_ren) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: binary write/read pointers with a wrap bit, flags from pointer compare.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int unsigned DLEN = FIFO_DLEN_DEF,
    parameter int unsigned ALEN = FIFO_ALEN_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    sync_fifo_core_if.slave   bus
);

    logic [ALEN:0] wptr_q, wptr_d;
    logic [ALEN:0] rptr_q, rptr_d;
    logic          wfull;
    logic          rempty;
    logic          ram_wen;
    logic          ram_ren;

    // Equal pointers mean empty; same address but opposite wrap bit means full.
    assign rempty = (wptr_q == rptr_q);
    assign wfull  = (wptr_q[ALEN] != rptr_q[ALEN]) &&
                    (wptr_q[ALEN-1:0] == rptr_q[ALEN-1:0]);

    assign bus.o_rempty = rempty;
    assign bus.o_wfull  = wfull;

    // Write side
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ram_wen = bus.i_wen & ~wfull;
        wptr_d  = wptr_q;
        if (ram_wen) begin
            wptr_d = wptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
        end
    end

    // Read side
    always_comb begin
        ram_ren = bus.i_ren & ~rempty;
        rptr_d  = rptr_q;
        if (ram_ren) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
        end
    end

    sdp_ram1 #(
        .DLEN (DLEN),
        .ALEN (ALEN)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .i_wen   (ram_wen),
        .i_waddr (wptr_q[ALEN-1:0]),
        .i_wdata (bus.i_wdata),
        .i_ren   (ram_ren),
        .i_raddr (rptr_q[ALEN-1:0]),
        .o_rdata (bus.o_rdata)
    );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Self-checking bench for sync_fifo_core (ALEN=2, DLEN=8): vector table, corner sequences, random vs queue model.
module tb_sync_fifo_core;

    localparam int DLEN  = 8;
    localparam int ALEN  = 2;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_core_if #(.DLEN(DLEN)) bus ();

    sync_fifo_core #(
        .DLEN (DLEN),
        .ALEN (ALEN)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic       wen;
        logic [7:0] wdata;
        logic       ren;
        logic [7:0] exp_rdata;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_q[$];
    logic [7:0] model_rdata = 8'h00;
    vec_t       tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model judges each side against start-of-cycle occupancy.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input string tag);
        bit acc_w;
        bit acc_r;
        bus.i_wen   = w;
        bus.i_wdata = d;
        bus.i_ren   = r;
        acc_r = r && (model_q.size() != 0);
        acc_w = w && (model_q.size() != DEPTH);
        @(posedge clk);
        #1;
        if (acc_r) model_rdata = model_q.pop_front();
        if (acc_w) model_q.push_back(d);
        check({tag, "/rdata"}, 32'(bus.o_rdata), 32'(model_rdata));
        check({tag, "/empty"}, 32'(bus.o_rempty), 32'(model_q.size() == 0));
        check({tag, "/full"},  32'(bus.o_wfull),  32'(model_q.size() == DEPTH));
        bus.i_wen = 1'b0;
        bus.i_ren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] stream[10];

        bus.i_wen   = 1'b0;
        bus.i_wdata = 8'h00;
        bus.i_ren   = 1'b0;

        // Reset values
        #12;
        check("reset/empty", 32'(bus.o_rempty), 32'd1);
        check("reset/full",  32'(bus.o_wfull),  32'd0);
        check("reset/rdata", 32'(bus.o_rdata),  32'd0);
        rstn = 1'b1;

        // Fill past full, drain past empty
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].wen, tbl[i].wdata, tbl[i].ren, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d/rdata_v", i), 32'(bus.o_rdata),  32'(tbl[i].exp_rdata));
            check($sformatf("tbl%0d/empty_v", i), 32'(bus.o_rempty), 32'(tbl[i].exp_empty));
            check($sformatf("tbl%0d/full_v", i),  32'(bus.o_wfull),  32'(tbl[i].exp_full));
        end

        // Simultaneous read and write while empty: write only, no write-through
        cycle(1'b1, 8'h66, 1'b1, "rw_empty");
        check("rw_empty/rdata_held", 32'(bus.o_rdata),  32'h44);
        check("rw_empty/not_empty",  32'(bus.o_rempty), 32'd0);

        // Simultaneous read and write while full: read only
        cycle(1'b1, 8'h77, 1'b0, "fill1");
        cycle(1'b1, 8'h88, 1'b0, "fill2");
        cycle(1'b1, 8'h99, 1'b0, "fill3");
        check("fill/full", 32'(bus.o_wfull), 32'd1);
        cycle(1'b1, 8'hAA, 1'b1, "rw_full");
        check("rw_full/rdata",    32'(bus.o_rdata), 32'h66);
        check("rw_full/not_full", 32'(bus.o_wfull), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, "drain1");
        cycle(1'b0, 8'h00, 1'b1, "drain2");
        cycle(1'b0, 8'h00, 1'b1, "drain3");
        check("drain/last",  32'(bus.o_rdata),  32'h99);
        check("drain/empty", 32'(bus.o_rempty), 32'd1);

        // Streaming 10 words across two address wraps
        for (int i = 0; i < 10; i++) stream[i] = 8'(8'hB0 + i);
        cycle(1'b1, stream[0], 1'b0, "stream0");
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, stream[i], 1'b1, $sformatf("stream%0d", i));
            check($sformatf("stream%0d/data", i), 32'(bus.o_rdata), 32'(stream[i-1]));
        end
        cycle(1'b0, 8'h00, 1'b1, "stream_last");
        check("stream_last/data",  32'(bus.o_rdata),  32'(stream[9]));
        check("stream_last/empty", 32'(bus.o_rempty), 32'd1);

        // Asynchronous reset while holding 3 words
        cycle(1'b1, 8'hC1, 1'b0, "hold1");
        cycle(1'b1, 8'hC2, 1'b1, "hold2");
        cycle(1'b1, 8'hC3, 1'b0, "hold3");
        cycle(1'b1, 8'hC4, 1'b0, "hold4");
        #2;
        rstn = 1'b0;
        #1;
        model_q.delete();
        model_rdata = 8'h00;
        check("mid_rst/empty", 32'(bus.o_rempty), 32'd1);
        check("mid_rst/full",  32'(bus.o_wfull),  32'd0);
        check("mid_rst/rdata", 32'(bus.o_rdata),  32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle(1'b1, 8'hD1, 1'b0, "post_rst_w1");
        cycle(1'b1, 8'hD2, 1'b0, "post_rst_w2");
        cycle(1'b1, 8'hD3, 1'b0, "post_rst_w3");
        cycle(1'b1, 8'hD4, 1'b0, "post_rst_w4");
        check("post_rst/full", 32'(bus.o_wfull), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, "post_rst_r1");
        check("post_rst/first", 32'(bus.o_rdata), 32'hD1);

        // Randomised traffic with alternating write-heavy and read-heavy phases
        for (int i = 0; i < 400; i++) begin
            logic w;
            logic r;
            if (((i / 40) % 2) == 0) begin
                w = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 30);
            end else begin
                w = ($urandom_range(0, 99) < 30);
                r = ($urandom_range(0, 99) < 75);
            end
            cycle(w, 8'($urandom), r, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
